// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_arb_pkg
//  Description : Shared state encoding and bus widths for the APB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_e;

endpackage : apb_arb_pkg
`default_nettype wire

// File: rtl/apb_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin winner search starting at ptr_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        logic             found;
        int               j;
        logic [IDX_W-1:0] jj;
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        j        = 0;
        jj       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j  = (int'(ptr_i) + k) % NREQ;
            jj = IDX_W'(j);
            if (!found && req_i[jj]) begin
                found        = 1'b1;
                onehot_o[jj] = 1'b1;
                idx_o        = jj;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_req_arbiter
//  Description : Round-robin sharing of one APB master between NREQ requesters,
//                with a BUSY watchdog that aborts transfers that never finish.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_write,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [DATA_W*NREQ-1:0]   req_wdata,
    input  logic [STRB_W*NREQ-1:0]   req_strb,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err,
    output logic                     timeout,
    output logic                     m_transfer,
    output logic                     m_read_write,
    output logic [ADDR_W-1:0]        m_w_paddr,
    output logic [ADDR_W-1:0]        m_r_paddr,
    output logic [DATA_W-1:0]        m_w_data,
    output logic [STRB_W-1:0]        m_strb,
    input  logic                     m_penable,
    input  logic                     m_pready,
    input  logic                     m_pslverr,
    input  logic [ADDR_W-1:0]        m_rdata
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e          state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                timeout_q, timeout_d;
    logic                m_transfer_q, m_transfer_d;
    logic                m_read_write_q, m_read_write_d;
    logic [ADDR_W-1:0]   m_w_paddr_q, m_w_paddr_d;
    logic [ADDR_W-1:0]   m_r_paddr_q, m_r_paddr_d;
    logic [DATA_W-1:0]   m_w_data_q, m_w_data_d;
    logic [STRB_W-1:0]   m_strb_q, m_strb_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_idx_q, win_idx_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;

    logic [NREQ-1:0]     pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   addr_arr  [NREQ];
    logic [DATA_W-1:0]   wdata_arr [NREQ];
    logic [STRB_W-1:0]   strb_arr  [NREQ];
    logic                pick_write;
    logic                unused_rdata_msb;

    assign unused_rdata_msb = m_rdata[ADDR_W-1];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[ADDR_W*g +: ADDR_W];
        assign wdata_arr[g] = req_wdata[DATA_W*g +: DATA_W];
        assign strb_arr[g]  = req_strb[STRB_W*g +: STRB_W];
    end

    assign pick_write = req_write[pick_idx];

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            done_q         <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            timeout_q      <= 1'b0;
            m_transfer_q   <= 1'b0;
            m_read_write_q <= 1'b0;
            m_w_paddr_q    <= '0;
            m_r_paddr_q    <= '0;
            m_w_data_q     <= '0;
            m_strb_q       <= '0;
            rr_ptr_q       <= '0;
            win_idx_q      <= '0;
            wdog_q         <= '0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            done_q         <= done_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            timeout_q      <= timeout_d;
            m_transfer_q   <= m_transfer_d;
            m_read_write_q <= m_read_write_d;
            m_w_paddr_q    <= m_w_paddr_d;
            m_r_paddr_q    <= m_r_paddr_d;
            m_w_data_q     <= m_w_data_d;
            m_strb_q       <= m_strb_d;
            rr_ptr_q       <= rr_ptr_d;
            win_idx_q      <= win_idx_d;
            wdog_q         <= wdog_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        done_d         = done_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        timeout_d      = timeout_q;
        m_transfer_d   = m_transfer_q;
        m_read_write_d = m_read_write_q;
        m_w_paddr_d    = m_w_paddr_q;
        m_r_paddr_d    = m_r_paddr_q;
        m_w_data_d     = m_w_data_q;
        m_strb_d       = m_strb_q;
        rr_ptr_d       = rr_ptr_q;
        win_idx_d      = win_idx_q;
        wdog_d         = wdog_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d        = BUSY;
                    gnt_d          = pick_oh;
                    win_idx_d      = pick_idx;
                    m_transfer_d   = 1'b1;
                    m_read_write_d = ~pick_write;
                    m_w_paddr_d    = pick_write ? addr_arr[pick_idx] : '0;
                    m_r_paddr_d    = pick_write ? '0 : addr_arr[pick_idx];
                    m_w_data_d     = wdata_arr[pick_idx];
                    m_strb_d       = strb_arr[pick_idx];
                    wdog_d         = '0;
                end
            end
            BUSY: begin
                wdog_d = wdog_q + 1'b1;
                // Completion outranks both the error abort and watchdog expiry.
                if (m_penable && m_pready) begin
                    state_d      = DONE;
                    done_d       = gnt_q;
                    err_d        = m_pslverr;
                    m_transfer_d = 1'b0;
                    if (m_read_write_q) begin
                        rdata_d = m_rdata[DATA_W-1:0];
                    end
                end else if (m_pslverr) begin
                    state_d      = DONE;
                    done_d       = gnt_q;
                    err_d        = 1'b1;
                    m_transfer_d = 1'b0;
                end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = DONE;
                    done_d       = gnt_q;
                    err_d        = 1'b1;
                    timeout_d    = 1'b1;
                    m_transfer_d = 1'b0;
                end
            end
            DONE: begin
                state_d   = IDLE;
                gnt_d     = '0;
                done_d    = '0;
                err_d     = 1'b0;
                timeout_d = 1'b0;
                wdog_d    = '0;
                rr_ptr_d  = (win_idx_q == IDX_W'(NREQ - 1)) ? '0 : win_idx_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign err          = err_q;
    assign timeout      = timeout_q;
    assign m_transfer   = m_transfer_q;
    assign m_read_write = m_read_write_q;
    assign m_w_paddr    = m_w_paddr_q;
    assign m_r_paddr    = m_r_paddr_q;
    assign m_w_data     = m_w_data_q;
    assign m_strb       = m_strb_q;

endmodule : apb_req_arbiter
`default_nettype wire
